// File: rtl/note_event_tracker_pkg.sv
// Shared types and constants for the note event tracker.
//  - note_t          : 8-bit note code {letter[3:0], octave[2:0], acc}
//  - DUR_*           : one-hot duration codes
//  - tracker_state_t : run tracker FSM states (ST_PEND only used with NOTE_DEBOUNCE_EN)
package note_event_tracker_pkg;

  typedef struct packed {
    logic [3:0] letter;
    logic [2:0] octave;
    logic       acc;
  } note_t;

  localparam logic [3:0] DUR_EIGHTH  = 4'b0001;
  localparam logic [3:0] DUR_QUARTER = 4'b0010;
  localparam logic [3:0] DUR_HALF    = 4'b0100;
  localparam logic [3:0] DUR_WHOLE   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_PEND
  } tracker_state_t;

endpackage

// File: rtl/note_event_tracker_if.sv
// Frame input / note event output bundle of the note event tracker.
//  master : tracker side (takes frames and note_ready, drives the event register)
//  slave  : environment side (frame source and event consumer)
interface note_event_tracker_if;
  import note_event_tracker_pkg::*;

  logic       frame_valid;
  logic       frame_pitched;
  note_t      frame_note;
  logic       note_ready;
  logic       note_valid;
  note_t      note;
  logic [3:0] duration;
  logic       overflow;

  modport master (
    input  frame_valid, frame_pitched, frame_note, note_ready,
    output note_valid, note, duration, overflow
  );

  modport slave (
    output frame_valid, frame_pitched, frame_note, note_ready,
    input  note_valid, note, duration, overflow
  );

endinterface

// File: rtl/note_event_tracker_classify.sv
// note_duration_classify: combinational run length -> {emit, one-hot duration}.
//  cnt      in  CNT_W  run length in frames
//  emit     out 1      run is long enough to be reported
//  duration out 4      one-hot duration code for the run length
module note_duration_classify
  import note_event_tracker_pkg::*;
#(
  parameter int unsigned MIN_FRAMES  = 2,
  parameter int unsigned EIGHTH_MAX  = 3,
  parameter int unsigned QUARTER_MAX = 7,
  parameter int unsigned HALF_MAX    = 15,
  parameter int unsigned CNT_W       = 5
) (
  input  logic [CNT_W-1:0] cnt,
  output logic             emit,
  output logic [3:0]       duration
);

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_FRAMES);
  localparam logic [CNT_W-1:0] EIGHTH_C  = CNT_W'(EIGHTH_MAX);
  localparam logic [CNT_W-1:0] QUARTER_C = CNT_W'(QUARTER_MAX);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF_MAX);

  always_comb begin
    emit = (cnt >= MIN_C);
    if (cnt <= EIGHTH_C)       duration = DUR_EIGHTH;
    else if (cnt <= QUARTER_C) duration = DUR_QUARTER;
    else if (cnt <= HALF_C)    duration = DUR_HALF;
    else                       duration = DUR_WHOLE;
  end

endmodule

// File: rtl/note_event_tracker.sv
// note_event_tracker: turns per-frame pitch classifications into {note, duration}
// events held in a single-entry valid/ready output register.
//  clk    in  system clock
//  reset  in  synchronous active-high reset
//  bus    note_event_tracker_if.master:
//         frame_valid/frame_pitched/frame_note in, note_ready in,
//         note_valid/note/duration/overflow out
// Optional feature: define NOTE_DEBOUNCE_EN to absorb single differing frames
// inside a run (one frame of extra termination latency).
module note_event_tracker
  import note_event_tracker_pkg::*;
#(
  parameter int unsigned MIN_FRAMES  = 2,
  parameter int unsigned EIGHTH_MAX  = 3,
  parameter int unsigned QUARTER_MAX = 7,
  parameter int unsigned HALF_MAX    = 15,
  parameter int unsigned MAX_FRAMES  = 22,
  parameter int unsigned CNT_W       = 5
) (
  input logic                  clk,
  input logic                  reset,
  note_event_tracker_if.master bus
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_FRAMES);

  tracker_state_t   state, state_n;
  note_t            cur_note, cur_note_n;
  logic [CNT_W-1:0] cnt, cnt_n, cls_cnt, cnt_inc;
  logic             frame_same;
  logic             ev_req, ev_fire, cls_emit;
  logic [3:0]       cls_dur;

`ifdef NOTE_DEBOUNCE_EN
  note_t            pend_note, pend_note_n;
  logic             pend_pitched, pend_pitched_n;
  logic             pend_match;
  logic [CNT_W-1:0] cnt_add2;
`endif

  assign frame_same = bus.frame_pitched && (bus.frame_note == cur_note);
  assign cnt_inc    = cnt + 1'b1;
`ifdef NOTE_DEBOUNCE_EN
  assign cnt_add2   = cnt + CNT_W'(2);
  // Rests compare equal to each other regardless of the note bits.
  assign pend_match = bus.frame_pitched ? (pend_pitched && (bus.frame_note == pend_note))
                                        : !pend_pitched;
`endif

  note_duration_classify #(
    .MIN_FRAMES (MIN_FRAMES),
    .EIGHTH_MAX (EIGHTH_MAX),
    .QUARTER_MAX(QUARTER_MAX),
    .HALF_MAX   (HALF_MAX),
    .CNT_W      (CNT_W)
  ) u_classify (
    .cnt     (cls_cnt),
    .emit    (cls_emit),
    .duration(cls_dur)
  );

  // Every event reports cur_note as it was before this frame.
  assign ev_fire = ev_req && cls_emit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cur_note     <= '0;
      cnt          <= '0;
`ifdef NOTE_DEBOUNCE_EN
      pend_note    <= '0;
      pend_pitched <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cur_note     <= cur_note_n;
      cnt          <= cnt_n;
`ifdef NOTE_DEBOUNCE_EN
      pend_note    <= pend_note_n;
      pend_pitched <= pend_pitched_n;
`endif
    end
  end

  always_comb begin
    state_n        = state;
    cur_note_n     = cur_note;
    cnt_n          = cnt;
    cls_cnt        = cnt;
    ev_req         = 1'b0;
`ifdef NOTE_DEBOUNCE_EN
    pend_note_n    = pend_note;
    pend_pitched_n = pend_pitched;
`endif
    if (bus.frame_valid) begin
      case (state)
        ST_IDLE: begin
          if (bus.frame_pitched) begin
            state_n    = ST_TRACK;
            cur_note_n = bus.frame_note;
            cnt_n      = CNT_W'(1);
          end
        end
        ST_TRACK: begin
          if (frame_same) begin
            if (cnt_inc == MAX_C) begin
              ev_req  = 1'b1;
              cls_cnt = MAX_C;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
`ifdef NOTE_DEBOUNCE_EN
            state_n        = ST_PEND;
            pend_note_n    = bus.frame_note;
            pend_pitched_n = bus.frame_pitched;
`else
            ev_req = 1'b1;
            if (bus.frame_pitched) begin
              cur_note_n = bus.frame_note;
              cnt_n      = CNT_W'(1);
            end else begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end
`endif
          end
        end
`ifdef NOTE_DEBOUNCE_EN
        ST_PEND: begin
          if (frame_same) begin
            // Glitch frame absorbed: it and this frame both count toward the run.
            state_n = ST_TRACK;
            if (cnt_add2 >= MAX_C) begin
              ev_req  = 1'b1;
              cls_cnt = MAX_C;
              cnt_n   = cnt_add2 - MAX_C;
            end else begin
              cnt_n = cnt_add2;
            end
          end else if (pend_match) begin
            ev_req = 1'b1;
            if (bus.frame_pitched) begin
              state_n    = ST_TRACK;
              cur_note_n = bus.frame_note;
              cnt_n      = CNT_W'(2);
            end else begin
              state_n = ST_IDLE;
              cnt_n   = '0;
            end
          end else begin
            pend_note_n    = bus.frame_note;
            pend_pitched_n = bus.frame_pitched;
          end
        end
`endif
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.note_valid <= 1'b0;
      bus.note       <= '0;
      bus.duration   <= '0;
      bus.overflow   <= 1'b0;
    end else if (ev_fire) begin
      if (!bus.note_valid || bus.note_ready) begin
        bus.note_valid <= 1'b1;
        bus.note       <= cur_note;
        bus.duration   <= cls_dur;
      end else begin
        bus.overflow <= 1'b1;
      end
    end else if (bus.note_valid && bus.note_ready) begin
      bus.note_valid <= 1'b0;
    end
  end

endmodule
